// File: rtl/lab3_cache_test_mem_responder.sv
// Word-addressed backing store for cache unit benches. It accepts one 4-byte request at a
// time and returns the response after a fixed, parameterised number of wait cycles.
module lab3_cache_test_mem_responder #(
   parameter int NUM_WORDS = 256,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   input  logic [76:0] memreq_msg,
   output logic        memresp_val,
   input  logic        memresp_rdy,
   output logic [46:0] memresp_msg
);

   localparam int AW = $clog2(NUM_WORDS);
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   localparam logic [2:0] T_READ  = 3'd0;
   localparam logic [2:0] T_WRITE = 3'd1;
   localparam logic [2:0] T_INIT  = 3'd2;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  type_;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   mem_resp_4B_t resp_q, resp_d;
   logic [31:0]  mem_q [NUM_WORDS];

   mem_req_4B_t  req;
   logic         accept;
   logic [AW-1:0] idx;
   logic [3:0]   byte_mask;
   logic [31:0]  bit_mask;
   logic [31:0]  rd_word;
   logic         is_write;
   logic         unused_addr_bits;

   assign req      = mem_req_4B_t'(memreq_msg);
   assign idx      = req.addr[AW+1:2];
   assign rd_word  = mem_q[idx];
   assign is_write = (req.type_ == T_WRITE) || (req.type_ == T_INIT);

   // Upper address bits alias onto the array; the byte offset is ignored.
   assign unused_addr_bits = ^{req.addr[31:AW+2], req.addr[1:0]};

   assign memreq_rdy  = reset && ((state_q == S_IDLE) || ((state_q == S_RESP) && memresp_rdy));
   assign accept      = memreq_val && memreq_rdy;
   assign memresp_val = (state_q == S_RESP);
   assign memresp_msg = resp_q;

   always_comb begin
      byte_mask = 4'b1111;
      case (req.len)
         2'd1:    byte_mask = 4'b0001;
         2'd2:    byte_mask = 4'b0011;
         2'd3:    byte_mask = 4'b0111;
         default: byte_mask = 4'b1111;
      endcase
      bit_mask = {{8{byte_mask[3]}}, {8{byte_mask[2]}}, {8{byte_mask[1]}}, {8{byte_mask[0]}}};
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      resp_d  = resp_q;

      case (state_q)
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            if (memresp_rdy && !accept) state_d = S_IDLE;
         end
         default: ;
      endcase

      // A new request may land from IDLE or, back-to-back, as the RESP response is taken.
      if (accept) begin
         resp_d.type_  = req.type_;
         resp_d.opaque = req.opaque;
         resp_d.test   = 2'b00;
         resp_d.len    = req.len;
         resp_d.data   = (req.type_ == T_READ) ? (rd_word & bit_mask) : 32'h0;
         state_d       = (LATENCY > 0) ? S_WAIT : S_RESP;
         cnt_d         = LAT_M1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         resp_q  <= resp_d;
      end
   end

   // NOTE: the array deliberately has no reset; contents survive reset and benches preload them.
   always_ff @(posedge clk) begin
      if (accept && is_write)
         mem_q[idx] <= (rd_word & ~bit_mask) | (req.data & bit_mask);
   end

endmodule

// File: tb/tb_lab3_cache_test_mem_responder.sv
// Self-checking bench: a timestamped single-slot model predicts val/rdy/msg every cycle,
// and directed sequences pin the results against hand-computed literals.
module tb_lab3_cache_test_mem_responder;

   localparam int NUM_WORDS = 256;
   localparam int LATENCY   = 2;
   localparam logic [2:0] T_RD   = 3'd0;
   localparam logic [2:0] T_WR   = 3'd1;
   localparam logic [2:0] T_INIT = 3'd2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        memreq_val = 1'b0;
   logic        memreq_rdy;
   logic [76:0] memreq_msg = '0;
   logic        memresp_val;
   logic        memresp_rdy = 1'b1;
   logic [46:0] memresp_msg;

   lab3_cache_test_mem_responder #(.NUM_WORDS(NUM_WORDS), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .reset       (reset),
      .memreq_val  (memreq_val),
      .memreq_rdy  (memreq_rdy),
      .memreq_msg  (memreq_msg),
      .memresp_val (memresp_val),
      .memresp_rdy (memresp_rdy),
      .memresp_msg (memresp_msg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out", name);
   endtask

   // Model: one transaction slot, stamped with the cycle its response becomes visible.
   logic [31:0] m_mem [NUM_WORDS];
   bit          m_pend  = 0;
   logic [46:0] m_resp  = '0;
   int          m_ready = 0;
   int          cyc     = 0;
   bit          chk_en  = 0;
   int          acc_cyc = 0;

   logic [46:0] got_msg [$];
   int          got_cyc [$];

   function automatic logic [31:0] lane_mask(input logic [1:0] len);
      int nb;
      nb = (len == 2'd0) ? 4 : int'(len);
      if (nb == 4) return 32'hFFFF_FFFF;
      return (32'h1 << (8 * nb)) - 32'h1;
   endfunction

   always @(posedge clk) begin
      bit          v, r;
      logic [2:0]  t;
      logic [7:0]  op;
      logic [31:0] a, d, rd, mk, wi;
      logic [1:0]  ln;
      if (!reset) begin
         m_pend = 0;
      end else begin
         v = m_pend && (cyc >= m_ready);
         r = !m_pend || (v && memresp_rdy);
         if (v && memresp_rdy) m_pend = 0;
         if (memreq_val && r) begin
            {t, op, a, ln, d} = memreq_msg;
            wi = (a >> 2) % 32'(NUM_WORDS);
            mk = lane_mask(ln);
            rd = (t == T_RD) ? (m_mem[wi] & mk) : 32'h0;
            if (t == T_WR || t == T_INIT) m_mem[wi] = (m_mem[wi] & ~mk) | (d & mk);
            m_resp  = {t, op, 2'b00, ln, rd};
            m_pend  = 1;
            m_ready = cyc + 1 + LATENCY;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit ev, er;
      if (chk_en) begin
         ev = m_pend && (cyc >= m_ready);
         er = reset && (!m_pend || (ev && memresp_rdy));
         check("memresp_val", 64'(memresp_val), 64'(ev));
         check("memreq_rdy", 64'(memreq_rdy), 64'(er));
         if (ev) check("memresp_msg", 64'(memresp_msg), 64'(m_resp));
         if (reset && memresp_val && memresp_rdy) begin
            got_msg.push_back(memresp_msg);
            got_cyc.push_back(cyc);
         end
      end
   end

   function automatic logic [46:0] resp_msg(input int k);
      if (k < got_msg.size()) return got_msg[k];
      return '1;
   endfunction

   function automatic int resp_cyc(input int k);
      if (k < got_cyc.size()) return got_cyc[k];
      return -1000;
   endfunction

   task automatic check_data(input string name, input int k, input logic [31:0] exp);
      logic [46:0] m;
      m = resp_msg(k);
      check(name, 64'(m[31:0]), 64'(exp));
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                       input logic [1:0] ln, input logic [31:0] d);
      bit ok;
      ok = 0;
      memreq_val = 1'b1;
      memreq_msg = {t, op, a, ln, d};
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = memreq_rdy;
         if (ok) acc_cyc = cyc;
         @(posedge clk);
         #1;
      end
      memreq_val = 1'b0;
      if (!ok) fail_now("send");
   endtask

   task automatic drain();
      int i;
      i = 0;
      @(negedge clk);
      while (m_pend && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (m_pend) fail_now("drain");
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base, a1, n_before, i_wait;
      logic [46:0] m, held;

      // Reset: two cycles low, checking from the second.
      @(posedge clk);
      #1 chk_en = 1;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("reset_val", 64'(memresp_val), 64'd0);
      check("reset_rdy", 64'(memreq_rdy), 64'd1);
      check("reset_msg", 64'(memresp_msg), 64'd0);
      @(posedge clk);
      #1;

      // 1. INIT then READ with latency and opaque echo.
      send(T_INIT, 8'h11, 32'h1E0, 2'd0, 32'hDEAD_BEEF);
      drain();
      base = got_msg.size();
      send(T_RD, 8'h5A, 32'h1E0, 2'd0, 32'h0);
      a1 = acc_cyc;
      drain();
      check_data("t1_data", base, 32'hDEAD_BEEF);
      m = resp_msg(base);
      check("t1_opaque", 64'(m[43:36]), 64'h5A);
      check("t1_latency", 64'(resp_cyc(base) - a1), 64'd3);

      // 2. Refill burst, back-to-back reads.
      for (int i = 0; i < 16; i++) send(T_INIT, 8'(i), 32'h7880 + 32'(4 * i), 2'd0, 32'(i));
      drain();
      base = got_msg.size();
      for (int i = 0; i < 16; i++) send(T_RD, 8'(i), 32'h7880 + 32'(4 * i), 2'd0, 32'h0);
      drain();
      for (int i = 0; i < 16; i++) check_data("t2_data", base + i, 32'(i));
      for (int i = 1; i < 16; i++) check("t2_spacing", 64'(resp_cyc(base + i) - resp_cyc(base + i - 1)), 64'd3);

      // 3. Partial write and partial reads.
      send(T_INIT, 8'h20, 32'h40, 2'd0, 32'h1122_3344);
      send(T_WR, 8'h21, 32'h40, 2'd1, 32'h0000_00AB);
      drain();
      base = got_msg.size();
      send(T_RD, 8'h22, 32'h40, 2'd0, 32'h0);
      send(T_RD, 8'h23, 32'h40, 2'd2, 32'h0);
      send(T_RD, 8'h24, 32'h40, 2'd3, 32'h0);
      drain();
      check_data("t3_full", base, 32'h1122_33AB);
      check_data("t3_len2", base + 1, 32'h0000_33AB);
      check_data("t3_len3", base + 2, 32'h0022_33AB);

      // 4. Backpressure for five RESP cycles, new request accepted on release.
      base = got_msg.size();
      send(T_RD, 8'h44, 32'h1E0, 2'd0, 32'h0);
      memresp_rdy = 1'b0;
      i_wait = 0;
      @(negedge clk);
      while (!memresp_val && i_wait < 20) begin
         @(negedge clk);
         i_wait++;
      end
      if (!memresp_val) fail_now("t4_wait_val");
      held = memresp_msg;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         memreq_val = 1'b1;
         memreq_msg = {T_RD, 8'h45, 32'h40, 2'd0, 32'h0};
         @(negedge clk);
         check("t4_val_held", 64'(memresp_val), 64'd1);
         check("t4_msg_held", 64'(memresp_msg), 64'(held));
         check("t4_rdy_low", 64'(memreq_rdy), 64'd0);
      end
      @(posedge clk);
      #1 memresp_rdy = 1'b1;
      @(negedge clk);
      check("t4_rdy_release", 64'(memreq_rdy), 64'd1);
      @(posedge clk);
      #1 memreq_val = 1'b0;
      drain();
      check_data("t4_first", base, 32'hDEAD_BEEF);
      check_data("t4_second", base + 1, 32'h1122_33AB);
      m = resp_msg(base + 1);
      check("t4_second_opaque", 64'(m[43:36]), 64'h45);
      check("t4_spacing", 64'(resp_cyc(base + 1) - resp_cyc(base)), 64'd3);

      // 5. Aliasing, plus an unknown type that must not touch the array.
      base = got_msg.size();
      send(T_WR, 8'h50, 32'h400, 2'd0, 32'h5);
      send(T_RD, 8'h51, 32'h000, 2'd0, 32'h0);
      send(3'd5, 8'h52, 32'h40, 2'd0, 32'hFFFF_FFFF);
      send(T_RD, 8'h53, 32'h40, 2'd0, 32'h0);
      drain();
      check_data("t5_write_resp", base, 32'h0);
      check_data("t5_alias", base + 1, 32'h5);
      check_data("t5_unknown_data", base + 2, 32'h0);
      m = resp_msg(base + 2);
      check("t5_unknown_type", 64'(m[46:44]), 64'd5);
      check_data("t5_unchanged", base + 3, 32'h1122_33AB);

      // 6. Reset while waiting drops the response but keeps the array.
      send(T_INIT, 8'h60, 32'h300, 2'd0, 32'hCAFE_F00D);
      drain();
      send(T_RD, 8'h61, 32'h300, 2'd0, 32'h0);
      n_before = got_msg.size();
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t6_val", 64'(memresp_val), 64'd0);
      check("t6_msg", 64'(memresp_msg), 64'd0);
      check("t6_rdy", 64'(memreq_rdy), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      check("t6_dropped", 64'(got_msg.size()), 64'(n_before));
      base = got_msg.size();
      send(T_RD, 8'h62, 32'h300, 2'd0, 32'h0);
      drain();
      check_data("t6_kept", base, 32'hCAFE_F00D);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
